mult_div_unit: RTL

- Iterative multiply/divide unit for the MIPS core's HI/LO datapath.
- Implements MULT, MULTU, DIV, DIVU, MTHI and MTLO, generalised to a parametrised operand width.
- Sits beside the ALU; the control unit issues an op and stalls on busy.
- HI/LO are owned and held here; MFHI/MFLO read the hi/lo outputs directly.

---
 rtl/mult_div_unit_pkg.sv | 34 +++
 rtl/mult_div_unit_step.sv | 47 ++++
 rtl/mult_div_unit.sv | 158 +++++++++++++++
 3 files changed

// File: rtl/mult_div_unit_pkg.sv
// mult_div_unit_pkg: shared constants for the HI/LO multiply/divide unit.
//   MD_* : op codes driven by the control unit on mult_div_unit.op
//   MD_MODE_* : md_step iteration mode select
//   md_is_* : op-code classification helpers
package mult_div_unit_pkg;

  localparam logic [2:0] MD_MULT  = 3'd0;
  localparam logic [2:0] MD_MULTU = 3'd1;
  localparam logic [2:0] MD_DIV   = 3'd2;
  localparam logic [2:0] MD_DIVU  = 3'd3;
  localparam logic [2:0] MD_MTHI  = 3'd4;
  localparam logic [2:0] MD_MTLO  = 3'd5;

  localparam logic MD_MODE_MUL = 1'b0;
  localparam logic MD_MODE_DIV = 1'b1;

  // Iterative ops: MULT, MULTU, DIV, DIVU
  function automatic logic md_is_arith(input logic [2:0] op);
    return (op == MD_MULT) || (op == MD_MULTU) || (op == MD_DIV) || (op == MD_DIVU);
  endfunction

  function automatic logic md_is_div(input logic [2:0] op);
    return (op == MD_DIV) || (op == MD_DIVU);
  endfunction

  function automatic logic md_is_signed(input logic [2:0] op);
    return (op == MD_MULT) || (op == MD_DIV);
  endfunction

  function automatic logic md_is_valid(input logic [2:0] op);
    return md_is_arith(op) || (op == MD_MTHI) || (op == MD_MTLO);
  endfunction

endpackage

// File: rtl/mult_div_unit_step.sv
// md_step: combinational single-iteration datapath for mult_div_unit.
//   acc     in  2*WIDTH  working accumulator
//   opnd    in  WIDTH    multiplicand (multiply) or divisor (divide)
//   mode    in  1        MD_MODE_MUL / MD_MODE_DIV
//   acc_nxt out 2*WIDTH  accumulator after one iteration
//   q_bit   out 1        quotient bit of this divide iteration (0 when multiplying)
// Multiply: acc = {partial product, remaining multiplier bits}; add opnd to the
// upper half when the multiplier LSB is set, then shift right with the carry.
// Divide (restoring): acc = {partial remainder, remaining dividend bits}; shift
// left, trial-subtract opnd. acc_nxt[0] is left 0 in divide mode; the caller
// shifts q_bit into it.
module md_step
  import mult_div_unit_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic [2*WIDTH-1:0] acc,
  input  logic [WIDTH-1:0]   opnd,
  input  logic               mode,
  output logic [2*WIDTH-1:0] acc_nxt,
  output logic               q_bit
);

  logic [WIDTH:0] sum;
  logic [WIDTH:0] diff;

  always_comb begin
    sum     = '0;
    diff    = '0;
    acc_nxt = acc;
    q_bit   = 1'b0;
    if (mode == MD_MODE_MUL) begin
      sum     = {1'b0, acc[2*WIDTH-1:WIDTH]} + (acc[0] ? {1'b0, opnd} : '0);
      acc_nxt = {sum, acc[WIDTH-1:1]};
    end else begin
      // Shifted remainder is WIDTH+1 bits; diff[WIDTH] set means it was below the divisor
      diff  = acc[2*WIDTH-1:WIDTH-1] - {1'b0, opnd};
      q_bit = ~diff[WIDTH];
      if (q_bit) begin
        acc_nxt = {diff[WIDTH-1:0], acc[WIDTH-2:0], 1'b0};
      end else begin
        acc_nxt = {acc[2*WIDTH-2:0], 1'b0};
      end
    end
  end

endmodule

// File: rtl/mult_div_unit.sv
// mult_div_unit: iterative MULT/MULTU/DIV/DIVU/MTHI/MTLO unit owning HI/LO.
//   clk         in  1      system clock, rising edge
//   reset_n     in  1      asynchronous active-low reset
//   start       in  1      issue pulse, sampled only in IDLE
//   op          in  3      MD_* op code
//   a           in  WIDTH  rs: multiplicand / dividend / MTHI-MTLO source
//   b           in  WIDTH  rt: multiplier / divisor
//   busy        out 1      high while CALC or FIX (control unit stalls)
//   done        out 1      one-cycle pulse when a MULT*/DIV* result was written
//   div_by_zero out 1      sticky; set by DIV*/DIVU with b==0, cleared on next accepted start
//   hi, lo      out WIDTH  HI/LO registers
// Latency: WIDTH+1 clocks from the start edge (2 for divide by zero).
module mult_div_unit
  import mult_div_unit_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int CNT_W = $clog2(WIDTH+1)
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             start,
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic             div_by_zero,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  typedef enum logic [1:0] {S_IDLE, S_CALC, S_FIX} state_e;

  state_e             state, state_nxt;
  logic [CNT_W-1:0]   cnt;
  logic [2*WIDTH-1:0] acc;
  logic [2*WIDTH-1:0] step_acc;
  logic               step_q;
  logic [WIDTH-1:0]   opnd;
  logic               is_div, neg_res, neg_rem, dbz;

  logic               accept, load, last_iter;
  logic               step_en, fix_wr;
  logic               sgn_a, sgn_b;
  logic [WIDTH-1:0]   mag_a, mag_b;
  logic [2*WIDTH-1:0] prod_s;
  logic [WIDTH-1:0]   res_hi, res_lo;

  // Operand magnitudes; the most-negative value maps to 2^(WIDTH-1), which is exact unsigned
  always_comb begin
    sgn_a = md_is_signed(op) && a[WIDTH-1];
    sgn_b = md_is_signed(op) && b[WIDTH-1];
    mag_a = sgn_a ? ('0 - a) : a;
    mag_b = sgn_b ? ('0 - b) : b;
  end

  assign accept    = start && (state == S_IDLE) && md_is_valid(op);
  assign load      = accept && md_is_arith(op);
  assign last_iter = (cnt == CNT_W'(WIDTH-1));

  md_step #(.WIDTH(WIDTH)) u_step (
    .acc     (acc),
    .opnd    (opnd),
    .mode    (is_div ? MD_MODE_DIV : MD_MODE_MUL),
    .acc_nxt (step_acc),
    .q_bit   (step_q)
  );

  // FSM: state register
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= S_IDLE;
    else          state <= state_nxt;
  end

  // FSM: next state
  always_comb begin
    state_nxt = state;
    unique case (state)
      S_IDLE:  if (load) state_nxt = S_CALC;
      S_CALC:  if (dbz || last_iter) state_nxt = S_FIX;
      S_FIX:   state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  // FSM: outputs / datapath enables
  always_comb begin
    busy    = (state != S_IDLE);
    step_en = (state == S_CALC) && !dbz;
    fix_wr  = (state == S_FIX);
  end

  // Sign correction applied on the FIX cycle
  always_comb begin
    prod_s = neg_res ? ('0 - acc) : acc;
    res_hi = prod_s[2*WIDTH-1:WIDTH];
    res_lo = prod_s[WIDTH-1:0];
    if (dbz) begin
      // Dividend was parked in the upper half at load time
      res_hi = acc[2*WIDTH-1:WIDTH];
      res_lo = '1;
    end else if (is_div) begin
      res_lo = neg_res ? ('0 - acc[WIDTH-1:0]) : acc[WIDTH-1:0];
      res_hi = neg_rem ? ('0 - acc[2*WIDTH-1:WIDTH]) : acc[2*WIDTH-1:WIDTH];
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt         <= '0;
      acc         <= '0;
      opnd        <= '0;
      is_div      <= 1'b0;
      neg_res     <= 1'b0;
      neg_rem     <= 1'b0;
      dbz         <= 1'b0;
      hi          <= '0;
      lo          <= '0;
      done        <= 1'b0;
      div_by_zero <= 1'b0;
    end else begin
      done <= fix_wr;

      if (accept) begin
        div_by_zero <= 1'b0;
        if (op == MD_MTHI) hi <= a;
        if (op == MD_MTLO) lo <= a;
      end

      if (load) begin
        cnt     <= '0;
        is_div  <= md_is_div(op);
        neg_res <= sgn_a ^ sgn_b;
        neg_rem <= sgn_a;
        dbz     <= md_is_div(op) && (b == '0);
        if (md_is_div(op)) begin
          acc  <= (b == '0) ? {a, {WIDTH{1'b0}}} : {{WIDTH{1'b0}}, mag_a};
          opnd <= mag_b;
        end else begin
          acc  <= {{WIDTH{1'b0}}, mag_b};
          opnd <= mag_a;
        end
      end

      if (step_en) begin
        acc <= {step_acc[2*WIDTH-1:1], step_acc[0] | step_q};
        cnt <= cnt + 1'b1;
      end

      if (fix_wr) begin
        hi <= res_hi;
        lo <= res_lo;
        if (dbz) div_by_zero <= 1'b1;
      end
    end
  end

endmodule
